uart_tx_byte: RTL and testbench
===============================

Name: uart_tx_byte

Overview:
- Byte-serial UART transmitter directly downstream of the command processor.
- Accepts one 8-bit result plus a one-cycle enable pulse and serialises it on txd: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Reports busy on rdy (0 = idle). The upstream stage waits for rdy = 0 before pulsing its enable.

Parameters:
- BAUD_DIV, 5208, clk cycles per bit period (e.g. 50 MHz / 9600); legal range 2..65535.
- PARITY_EN, 0, 1 = insert a parity bit after D7.
- PARITY_ODD, 0, parity sense when PARITY_EN = 1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- res  input  1  asynchronous, active-low reset.
- din_tx  input  8  byte to transmit; sampled only when accepted.
- en_din_tx  input  1  transmit request; single-cycle pulse is sufficient.
- txd  output  1  serial line; idle high.
- rdy  output  1  0 = idle and able to accept, 1 = frame in progress.

Behaviour:
- Reset (res = 0, asynchronous):
  - txd = 1, rdy = 0, state = IDLE.
  - Bit counter, baud counter and shift register cleared.
  - Asserting reset mid-frame aborts the frame immediately: txd goes high with no glitch low.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE. Any illegal encoding -> IDLE with txd = 1, rdy = 0.
- IDLE:
  - txd = 1, rdy = 0.
  - On a posedge with en_din_tx = 1: latch din_tx into the shift register, compute the parity bit, clear the baud counter, go to START.
  - At that same edge, register txd <= 0 and rdy <= 1 (zero-cycle acceptance latency; txd falls at the accepting edge).
- Baud counter:
  - Counts 0..BAUD_DIV-1.
  - Each bit is held on txd for exactly BAUD_DIV clk cycles.
  - The state or bit advance happens at the edge where the counter equals BAUD_DIV-1; the counter then wraps to 0.
- START: txd = 0 for one bit period, then DATA.
- DATA:
  - txd = shift_reg[0]; shift right at each bit-period end.
  - 3-bit bit counter 0..7; after bit 7 go to PARITY, or to STOP if PARITY_EN = 0.
- PARITY:
  - txd = ^data XOR PARITY_ODD, computed from the latched byte.
  - Even: total number of ones in data + parity is even.
- STOP:
  - txd = 1 for STOP_BITS bit periods.
  - At the edge ending the last stop period: state = IDLE, rdy <= 0.
- Frame length: (1 + 8 + PARITY_EN + STOP_BITS) * BAUD_DIV cycles from the accepting edge to the rdy-falling edge.
- en_din_tx while rdy = 1 (including the final cycle of STOP) is ignored. No queuing; din_tx changes have no effect on the frame in progress.
- Back-to-back frames:
  - The first cycle with rdy = 0 may accept a new request.
  - The new start bit then follows the stop bit(s) with no extra idle gap.
- txd and rdy are driven directly from flops (no combinational path from inputs).

Test Plan:
1. Reset, then BAUD_DIV = 4, PARITY_EN = 0, STOP_BITS = 1. Pulse en_din_tx one cycle with din_tx = 8'h5A -> txd sequence (4 cycles each): 0 | 0,1,0,1,1,0,1,0 | 1. rdy high for exactly 40 cycles, then 0.
2. PARITY_EN = 1, PARITY_ODD = 0, din_tx = 8'h5A -> parity bit 0 inserted after D7; frame 44 cycles. With PARITY_ODD = 1 -> parity bit 1. With din_tx = 8'h07 and even parity -> parity bit 1.
3. Busy rejection: during the frame of 8'hA5, pulse en_din_tx with 8'hFF at cycles 5 and 39 (last STOP cycle) -> both ignored; txd carries only 8'hA5; rdy falls at cycle 40.
4. Back-to-back: second request (8'h3C) asserted in the first cycle rdy = 0 -> start bit begins at that edge; no idle high period between frames beyond the stop bit.
5. STOP_BITS = 2, din_tx = 8'h00 -> eight 0 data bits, then txd high for 8 cycles; rdy high for 44 cycles.
6. Reset mid-frame: assert res = 0 during DATA bit 3 -> txd = 1 and rdy = 0 immediately (asynchronous). After release, idle until the next en_din_tx; a fresh 8'h81 frame is transmitted correctly.

Source files
------------

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: byte-serial UART transmitter.
// Frame: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
// Each bit lasts BAUD_DIV clk cycles. rdy = 1 while a frame is in flight.
// txd and rdy come straight from flops.
module uart_tx_byte #(
  parameter int unsigned BAUD_DIV   = 5208,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] din_tx,
  input  logic       en_din_tx,
  output logic       txd,
  output logic       rdy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 32'd1);
  localparam logic        STOP_LAST = (STOP_BITS == 32'd2) ? 1'b1 : 1'b0;
  localparam logic        PAR_EN    = (PARITY_EN != 32'd0) ? 1'b1 : 1'b0;
  localparam logic        PAR_ODD   = (PARITY_ODD != 32'd0) ? 1'b1 : 1'b0;

  // Parity bit for a byte: even sense gives an even total count of ones.
  function automatic logic parity_f(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] baud_cnt_r, baud_cnt_nxt_s;
  logic [2:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic        stop_cnt_r, stop_cnt_nxt_s;
  logic [7:0]  shift_r, shift_nxt_s;
  logic        par_r, par_nxt_s;
  logic        txd_r, txd_nxt_s;
  logic        rdy_r, rdy_nxt_s;
  logic        baud_end_s;

  // Next-state and next-output logic; txd/rdy are computed one edge ahead
  // so that the registered copies change exactly at bit boundaries.
  always_comb begin
    state_nxt_s    = state_r;
    baud_cnt_nxt_s = baud_cnt_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    stop_cnt_nxt_s = stop_cnt_r;
    shift_nxt_s    = shift_r;
    par_nxt_s      = par_r;
    txd_nxt_s      = txd_r;
    rdy_nxt_s      = rdy_r;
    baud_end_s     = (baud_cnt_r == BAUD_LAST);

    case (state_r)
      ST_IDLE: begin
        if (en_din_tx) begin
          // Accepting edge: start bit goes out immediately.
          shift_nxt_s    = din_tx;
          par_nxt_s      = parity_f(din_tx, PAR_ODD);
          baud_cnt_nxt_s = 16'd0;
          state_nxt_s    = ST_START;
          txd_nxt_s      = 1'b0;
          rdy_nxt_s      = 1'b1;
        end else begin
          txd_nxt_s      = 1'b1;
          rdy_nxt_s      = 1'b0;
        end
      end

      ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
        if (!baud_end_s) begin
          baud_cnt_nxt_s = baud_cnt_r + 16'd1;
        end else begin
          baud_cnt_nxt_s = 16'd0;
          case (state_r)
            ST_START: begin
              state_nxt_s   = ST_DATA;
              bit_cnt_nxt_s = 3'd0;
              txd_nxt_s     = shift_r[0];
            end
            ST_DATA: begin
              shift_nxt_s = {1'b0, shift_r[7:1]};
              if (bit_cnt_r == 3'd7) begin
                if (PAR_EN) begin
                  state_nxt_s = ST_PARITY;
                  txd_nxt_s   = par_r;
                end else begin
                  state_nxt_s    = ST_STOP;
                  stop_cnt_nxt_s = 1'b0;
                  txd_nxt_s      = 1'b1;
                end
              end else begin
                bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                txd_nxt_s     = shift_r[1];
              end
            end
            ST_PARITY: begin
              state_nxt_s    = ST_STOP;
              stop_cnt_nxt_s = 1'b0;
              txd_nxt_s      = 1'b1;
            end
            ST_STOP: begin
              if (stop_cnt_r == STOP_LAST) begin
                state_nxt_s = ST_IDLE;
                txd_nxt_s   = 1'b1;
                rdy_nxt_s   = 1'b0;
              end else begin
                stop_cnt_nxt_s = stop_cnt_r + 1'b1;
              end
            end
            default: begin
              state_nxt_s = ST_IDLE;
              txd_nxt_s   = 1'b1;
              rdy_nxt_s   = 1'b0;
            end
          endcase
        end
      end

      default: begin
        // Unreachable encodings recover to a quiet idle line.
        state_nxt_s    = ST_IDLE;
        baud_cnt_nxt_s = 16'd0;
        bit_cnt_nxt_s  = 3'd0;
        stop_cnt_nxt_s = 1'b0;
        txd_nxt_s      = 1'b1;
        rdy_nxt_s      = 1'b0;
      end
    endcase
  end

  // State, counters, data and output flops; reset forces the line high at once.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= 16'd0;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      shift_r    <= 8'd0;
      par_r      <= 1'b0;
      txd_r      <= 1'b1;
      rdy_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      baud_cnt_r <= baud_cnt_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      stop_cnt_r <= stop_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      par_r      <= par_nxt_s;
      txd_r      <= txd_nxt_s;
      rdy_r      <= rdy_nxt_s;
    end
  end

  assign txd = txd_r;
  assign rdy = rdy_r;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Directed bench for uart_tx_byte with BAUD_DIV = 4.
// Four instances cover no parity, even parity, odd parity and two stop bits.
// Expected frames are written as {stop bits, parity, data, start}, LSB sent first.
module tb_uart_tx_byte;

  logic       clk;
  logic       res;
  logic [7:0] din;
  logic [3:0] en_s;
  logic [3:0] txd_s;
  logic [3:0] rdy_s;
  int         sel;
  logic       txd_sel;
  logic       rdy_sel;
  int         errors;
  int         checks;

  uart_tx_byte #(.BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_n (
    .clk(clk), .res(res), .din_tx(din), .en_din_tx(en_s[0]), .txd(txd_s[0]), .rdy(rdy_s[0]));
  uart_tx_byte #(.BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_e (
    .clk(clk), .res(res), .din_tx(din), .en_din_tx(en_s[1]), .txd(txd_s[1]), .rdy(rdy_s[1]));
  uart_tx_byte #(.BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut_o (
    .clk(clk), .res(res), .din_tx(din), .en_din_tx(en_s[2]), .txd(txd_s[2]), .rdy(rdy_s[2]));
  uart_tx_byte #(.BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_s2 (
    .clk(clk), .res(res), .din_tx(din), .en_din_tx(en_s[3]), .txd(txd_s[3]), .rdy(rdy_s[3]));

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the instance under test to a common observation point.
  always_comb begin
    txd_sel = txd_s[sel[1:0]];
    rdy_sel = rdy_s[sel[1:0]];
  end

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Called at a negedge: request a frame, return at the negedge after the accepting edge.
  task automatic kick(input int s, input logic [7:0] data);
    sel     = s;
    din     = data;
    en_s[s] = 1'b1;
    @(negedge clk);
    en_s[s] = 1'b0;
  endtask

  // Check every cycle of a frame; optionally pulse en_din_tx with 8'hFF at
  // cycles 5 and 39 to show busy requests are ignored.
  task automatic frame(input string tag, input int s, input int nbits,
                       input logic [11:0] expv, input bit inject);
    sel = s;
    for (int c = 0; c < nbits * 4; c++) begin
      chk({tag, "_txd"}, txd_sel, expv[c / 4]);
      chk({tag, "_rdy"}, rdy_sel, 1'b1);
      if (inject && (c == 5 || c == 39)) begin
        din     = 8'hFF;
        en_s[s] = 1'b1;
      end else begin
        en_s[s] = 1'b0;
      end
      @(negedge clk);
    end
    en_s[s] = 1'b0;
    chk({tag, "_end_rdy"}, rdy_sel, 1'b0);
    chk({tag, "_end_txd"}, txd_sel, 1'b1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    sel    = 0;
    res    = 1'b0;
    din    = 8'h00;
    en_s   = 4'b0000;

    // Reset state of every instance.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sel = i;
      #1;
      chk("reset_txd", txd_sel, 1'b1);
      chk("reset_rdy", rdy_sel, 1'b0);
    end
    res = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 8N1 frame of 8'h5A, 40 cycles.
    kick(0, 8'h5A);
    frame("n_5a", 0, 10, {2'b00, 1'b1, 8'h5A, 1'b0}, 1'b0);
    // Back-to-back: request in the first rdy = 0 cycle.
    kick(0, 8'h3C);
    frame("b2b_3c", 0, 10, {2'b00, 1'b1, 8'h3C, 1'b0}, 1'b0);
    repeat (2) @(negedge clk);

    // Parity frames, 44 cycles each.
    kick(1, 8'h5A);
    frame("even_5a", 1, 11, {1'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 1'b0);
    kick(2, 8'h5A);
    frame("odd_5a", 2, 11, {1'b0, 1'b1, 1'b1, 8'h5A, 1'b0}, 1'b0);
    kick(1, 8'h07);
    frame("even_07", 1, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 1'b0);
    repeat (2) @(negedge clk);

    // Busy rejection during an 8'hA5 frame.
    kick(0, 8'hA5);
    frame("busy_a5", 0, 10, {2'b00, 1'b1, 8'hA5, 1'b0}, 1'b1);
    @(negedge clk);
    chk("busy_after_rdy", rdy_sel, 1'b0);
    chk("busy_after_txd", txd_sel, 1'b1);
    repeat (2) @(negedge clk);

    // Two stop bits, all-zero data, 44 cycles.
    kick(3, 8'h00);
    frame("stop2_00", 3, 11, {1'b0, 2'b11, 8'h00, 1'b0}, 1'b0);
    repeat (2) @(negedge clk);

    // Reset during DATA bit 3 (cycle 17, line low for 8'h81 bit 3).
    kick(0, 8'h81);
    repeat (17) @(negedge clk);
    chk("mid_pre_txd", txd_sel, 1'b0);
    chk("mid_pre_rdy", rdy_sel, 1'b1);
    #2;
    res = 1'b0;
    #1;
    chk("mid_rst_txd", txd_sel, 1'b1);
    chk("mid_rst_rdy", rdy_sel, 1'b0);
    @(negedge clk);
    res = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle_txd", txd_sel, 1'b1);
      chk("post_rst_idle_rdy", rdy_sel, 1'b0);
    end
    kick(0, 8'h81);
    frame("fresh_81", 0, 10, {2'b00, 1'b1, 8'h81, 1'b0}, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
